mem_wb_reg: RTL

MEM_WB_REG -- requirements
Module: mem_wb_reg

---
 rtl/mem_wb_reg.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/mem_wb_reg.sv
// ---------------------------------------------------------------------------
// mem_wb_reg -- MEM/WB pipeline register.
//
// Formats load data (byte/halfword select with sign or zero extension),
// flags misaligned loads and suppresses their register write, then
// registers everything into the WB stage. Stall holds all state. Flush
// inserts a bubble and takes priority over stall. A retired-instruction
// counter advances whenever a valid WB instruction leaves the stage.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   ALUResult_M, read_data_M,
//   PCplus4M, RdM, RegWriteM,
//   ResultSrcM, funct3M, ValidM     MEM-stage inputs
//   StallW, FlushW                  hold / bubble controls
//   ALUResult_W, read_data_W,
//   PCplus4W, RdW, RegWriteW,
//   ResultSrcW, ValidW              registered WB-stage copies
//   LoadMisalignW                   registered misaligned-load flag
//   RetireCount                     retired-instruction count (wraps)
// ---------------------------------------------------------------------------
module mem_wb_reg #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      ALUResult_M,
  input  logic [31:0]      read_data_M,
  input  logic [31:0]      PCplus4M,
  input  logic [4:0]       RdM,
  input  logic             RegWriteM,
  input  logic [1:0]       ResultSrcM,
  input  logic [2:0]       funct3M,
  input  logic             ValidM,
  input  logic             StallW,
  input  logic             FlushW,
  output logic [31:0]      ALUResult_W,
  output logic [31:0]      read_data_W,
  output logic [31:0]      PCplus4W,
  output logic [4:0]       RdW,
  output logic             RegWriteW,
  output logic [1:0]       ResultSrcW,
  output logic             ValidW,
  output logic             LoadMisalignW,
  output logic [CNT_W-1:0] RetireCount
);

  // Extract and extend the addressed byte/halfword of a little-endian word.
  function automatic logic [31:0] format_load(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input logic [2:0]  f3);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    case (off)
      2'b00:   byte_v = word[7:0];
      2'b01:   byte_v = word[15:8];
      2'b10:   byte_v = word[23:16];
      2'b11:   byte_v = word[31:24];
      default: byte_v = word[7:0];
    endcase
    half_v = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  format_load = {{24{byte_v[7]}}, byte_v};
      3'b100:  format_load = {24'h000000, byte_v};
      3'b001:  format_load = {{16{half_v[15]}}, half_v};
      3'b101:  format_load = {16'h0000, half_v};
      default: format_load = word;
    endcase
  endfunction

  // Halfword loads need an even offset; word loads need offset zero.
  function automatic logic load_misaligned(input logic [1:0] off,
                                           input logic [2:0] f3);
    case (f3)
      3'b001:  load_misaligned = off[0];
      3'b101:  load_misaligned = off[0];
      3'b010:  load_misaligned = (off != 2'b00);
      default: load_misaligned = 1'b0;
    endcase
  endfunction

  logic [31:0] load_data_s;
  logic        misalign_s;
  logic        regwrite_s;

  logic [31:0]      alu_r;
  logic [31:0]      rdata_r;
  logic [31:0]      pc4_r;
  logic [4:0]       rd_r;
  logic             regwrite_r;
  logic [1:0]       rsrc_r;
  logic             valid_r;
  logic             misalign_r;
  logic [CNT_W-1:0] retire_r;

  // M-side next values: formatted load data, misalign flag, write enable.
  always_comb begin
    load_data_s = 32'h0000_0000;
    misalign_s  = 1'b0;
    regwrite_s  = 1'b0;
    if ((ResultSrcM == 2'b01) && ValidM) begin
      misalign_s = load_misaligned(ALUResult_M[1:0], funct3M);
    end else begin
      misalign_s = 1'b0;
    end
    if (misalign_s) begin
      load_data_s = 32'h0000_0000;
    end else begin
      load_data_s = format_load(read_data_M, ALUResult_M[1:0], funct3M);
    end
    regwrite_s = RegWriteM & ValidM & (RdM != 5'd0) & ~misalign_s;
  end

  // Pipeline register: flush beats stall, stall holds, otherwise capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_r      <= 32'h0000_0000;
      rdata_r    <= 32'h0000_0000;
      pc4_r      <= 32'h0000_0000;
      rd_r       <= 5'd0;
      regwrite_r <= 1'b0;
      rsrc_r     <= 2'b00;
      valid_r    <= 1'b0;
      misalign_r <= 1'b0;
    end else if (FlushW) begin
      alu_r      <= 32'h0000_0000;
      rdata_r    <= 32'h0000_0000;
      pc4_r      <= 32'h0000_0000;
      rd_r       <= 5'd0;
      regwrite_r <= 1'b0;
      rsrc_r     <= 2'b00;
      valid_r    <= 1'b0;
      misalign_r <= 1'b0;
    end else if (!StallW) begin
      alu_r      <= ALUResult_M;
      rdata_r    <= load_data_s;
      pc4_r      <= PCplus4M;
      rd_r       <= RdM;
      regwrite_r <= regwrite_s;
      rsrc_r     <= ResultSrcM;
      valid_r    <= ValidM;
      misalign_r <= misalign_s;
    end else begin
      alu_r      <= alu_r;
      rdata_r    <= rdata_r;
      pc4_r      <= pc4_r;
      rd_r       <= rd_r;
      regwrite_r <= regwrite_r;
      rsrc_r     <= rsrc_r;
      valid_r    <= valid_r;
      misalign_r <= misalign_r;
    end
  end

  // Retire counter: the instruction already in WB retires as it leaves,
  // so a flush (which kills the incoming one) does not block the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_r <= {CNT_W{1'b0}};
    end else if (valid_r && !StallW) begin
      retire_r <= retire_r + CNT_W'(1);
    end else begin
      retire_r <= retire_r;
    end
  end

  assign ALUResult_W   = alu_r;
  assign read_data_W   = rdata_r;
  assign PCplus4W      = pc4_r;
  assign RdW           = rd_r;
  assign RegWriteW     = regwrite_r;
  assign ResultSrcW    = rsrc_r;
  assign ValidW        = valid_r;
  assign LoadMisalignW = misalign_r;
  assign RetireCount   = retire_r;

endmodule
